// File: rtl/rom_prefetch_if.sv
// rom_prefetch_if: bundles the ROM request/response and core fetch handshake
// signals of the instruction prefetch stage.
//   master : the prefetch unit (drives ROM request and instruction outputs)
//   slave  : the environment (ROM + core), driving read data and fetch controls
interface rom_prefetch_if;
  logic [31:0] rom_addr;     // byte address to ROM
  logic        rom_cs;       // ROM read request
  logic [31:0] rom_rdata;    // ROM read data, valid the cycle after rom_cs
  logic        fetch_en;     // permits new ROM requests
  logic        instr_valid;  // head instruction present
  logic [31:0] instr_rdata;  // head instruction word
  logic [31:0] instr_addr;   // head instruction byte address
  logic        instr_ready;  // core accepts head
  logic        branch_req;   // single-cycle redirect pulse
  logic [31:0] branch_addr;  // redirect target, bits [1:0] ignored

  modport master (
    output rom_addr, rom_cs, instr_valid, instr_rdata, instr_addr,
    input  rom_rdata, fetch_en, instr_ready, branch_req, branch_addr
  );

  modport slave (
    input  rom_addr, rom_cs, instr_valid, instr_rdata, instr_addr,
    output rom_rdata, fetch_en, instr_ready, branch_req, branch_addr
  );
endinterface

// File: rtl/rom_prefetch.sv
// rom_prefetch: instruction prefetch stage between a 1-cycle registered ROM
// and the core fetch port. Issues sequential word addresses, captures the
// returned word one cycle later into a DEPTH-entry FIFO, and hands
// instructions to the core with valid/ready. A branch flushes buffered and
// in-flight words and restarts fetch at the target.
// Ports:
//   HCLK    : clock, all state on rising edge
//   HRESET  : synchronous active-high reset
//   bus     : rom_prefetch_if.master (ROM request/response, core handshake,
//             branch redirect)
module rom_prefetch #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic          HCLK,
  input  logic          HRESET,
  rom_prefetch_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_addr_q, inflight_addr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   fifo_addr_q [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];

  logic [CW-1:0] occupancy;
  logic          issue;
  logic          push;
  logic          pop;
  logic          instr_valid;

  // Occupancy reserves a slot for the word already in flight; a same-cycle
  // pop earns no credit, so the FIFO can never overflow.
  assign occupancy   = count_q + CW'(inflight_q);
  assign issue       = ~HRESET & bus.fetch_en & ~bus.branch_req
                       & (occupancy < CW'(DEPTH));
  assign instr_valid = (count_q != '0);
  assign push        = inflight_q & ~bus.branch_req;
  assign pop         = instr_valid & bus.instr_ready & ~bus.branch_req;

  assign bus.rom_cs      = issue;
  assign bus.rom_addr    = fetch_pc_q;
  assign bus.instr_valid = instr_valid;
  assign bus.instr_rdata = instr_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign bus.instr_addr  = instr_valid ? fifo_addr_q[rd_ptr_q] : '0;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    fetch_pc_d      = fetch_pc_q;
    inflight_d      = inflight_q;
    inflight_addr_d = inflight_addr_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q;

    if (bus.branch_req) begin
      // Flush wins: drop buffered and in-flight words, suppress push/pop.
      fetch_pc_d = {bus.branch_addr[31:2], 2'b00};
      inflight_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        inflight_addr_d = fetch_pc_q;
        fetch_pc_d      = fetch_pc_q + 32'd4;  // wraps modulo 2^32
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      fetch_pc_q      <= BOOT_ADDR;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      fetch_pc_q      <= fetch_pc_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
    end
  end

  // NOTE: FIFO storage has no reset; count_q gates visibility, so stale entries are never observed.
  always_ff @(posedge HCLK) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= inflight_addr_q;
      fifo_data_q[wr_ptr_q] <= bus.rom_rdata;
    end
  end
endmodule

// File: doc/rom_prefetch.md
Name: rom_prefetch

Overview:
Instruction prefetch stage sitting directly upstream of the instruction ROM (1-cycle registered read) and downstream of the core fetch port.
- Issues sequential word addresses with chip-select to the ROM.
- Captures read data one cycle later into a small FIFO.
- Presents instructions to the core with a valid/ready handshake.
- Handles branch redirects by flushing buffered and in-flight words.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
BOOT_ADDR, 32'h0000_0000, first fetch address after reset (word aligned)

Ports:
HCLK  input  1  clock, all state on rising edge
HRESET  input  1  synchronous reset, active-high
rom_addr  output  32  byte address to ROM; equals fetch_pc
rom_cs  output  1  ROM read request; ROM returns word on rom_rdata during next cycle
rom_rdata  input  32  ROM read data (registered in ROM, 0 when prior cs=0)
fetch_en  input  1  permits new ROM requests
instr_valid  output  1  FIFO head holds an instruction
instr_rdata  output  32  head instruction word
instr_addr  output  32  byte address of head instruction
instr_ready  input  1  core accepts head when instr_valid=1
branch_req  input  1  redirect request, single-cycle pulse
branch_addr  input  32  redirect target; bits [1:0] ignored

Behaviour:
- State: fetch_pc[31:0], inflight (1 bit), inflight_addr[31:0], FIFO of DEPTH {addr,data} entries, rd/wr pointers, count (0..DEPTH).
- Reset (HRESET=1 at edge): fetch_pc<=BOOT_ADDR, inflight<=0, count<=0, pointers<=0. While HRESET=1, rom_cs=0.
- Reset outputs: rom_cs=0, rom_addr=BOOT_ADDR, instr_valid=0, instr_rdata=0, instr_addr=0.
- Reset mid-operation: same effect; pending ROM data is discarded.
- rom_cs (combinational) = ~HRESET & fetch_en & ~branch_req & (count + inflight < DEPTH).
  - No credit is taken for a same-cycle pop, so overflow is impossible.
- Issue: on an edge with rom_cs=1: inflight<=1, inflight_addr<=fetch_pc, fetch_pc<=fetch_pc+4.
  - fetch_pc wraps modulo 2^32 (0xFFFF_FFFC -> 0).
- Issue when rom_cs=0: inflight<=0.
- Capture: inflight=1 marks rom_rdata valid this cycle. At the edge, {inflight_addr, rom_rdata} is pushed unless branch_req=1.
- Output: instr_valid = (count!=0). instr_rdata/instr_addr show the head entry when valid, 0 otherwise.
  - Pop on edge with instr_valid & instr_ready & ~branch_req.
  - Push and pop in the same cycle leave count unchanged.
- Branch (branch_req=1 at edge):
  - count<=0, pointers<=0, inflight<=0, fetch_pc<={branch_addr[31:2],2'b00}.
  - Same-cycle push and pop are both suppressed; flush wins over everything except reset.
- Branch timing: branch at cycle b -> rom_cs=1, rom_addr=target at b+1 -> instr_valid with target at b+3.
- Latency: first cycle after reset release: rom_cs=1, rom_addr=BOOT_ADDR. instr_valid rises 2 cycles later.
- Throughput: with instr_ready held 1 and fetch_en=1, one instruction per cycle sustained; count settles at 1.
- fetch_en=0: no new requests. An in-flight word is still captured. FIFO drains normally.
- Full: count=DEPTH, or count=DEPTH-1 with inflight=1 -> rom_cs=0 until a pop.
- instr_ready while instr_valid=0: ignored.
- Head entry and instr_valid stay stable until popped or flushed.

Test Plan:
- Reset release with ROM preloaded with mem[i]=0x1000+i, instr_ready=1 -> rom_addr 0,4,8,... on consecutive cycles. instr_valid first high 2 cycles after release with addr 0, data 0x1000. Then 0x1001, 0x1002 every cycle with no gaps.
- instr_ready=0 for 10 cycles -> exactly 4 requests issued (0x0..0xC), count=4, rom_cs=0. Raise instr_ready -> words 0x1000..0x1003 in order, then fetching resumes at 0x10.
- branch_req with branch_addr=0x0000_0042 while FIFO holds 3 entries and one word is in flight -> instr_valid=0 next cycle. rom_addr=0x40 the cycle after the branch. Next delivered instr_addr=0x40 with data 0x1010. No stale word is delivered.
- branch_req and instr_ready=1 in the same cycle with a valid head -> head not consumed, FIFO emptied. Branch with BOOT_ADDR=0xFFFF_FFF8 -> fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- fetch_en dropped while one word is in flight -> that word is still delivered. No further rom_cs. Re-raising fetch_en resumes at the next sequential address.
- HRESET asserted for 1 cycle mid-stream with FIFO partly full -> instr_valid=0 and rom_cs=0 during reset. Fetch restarts at BOOT_ADDR; no pre-reset word appears.
